stencil_op_affine_ctrl: RTL



---
 rtl/stencil_op_affine_ctrl_if.sv | 22 ++
 rtl/stencil_op_affine_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/stencil_op_affine_ctrl_if.sv
// Port bundle between an affine loop-nest controller and the unified stencil buffer.
// The master side drives start/flush/stall; the slave (controller) returns enable,
// iteration vector and status.
interface stencil_op_affine_ctrl_if;
  logic             flush;
  logic             start;
  logic             stall;
  logic             en;
  logic [2:0][15:0] ctrl_vars;
  logic             busy;
  logic             done;

  modport master (
    output flush, start, stall,
    input  en, ctrl_vars, busy, done
  );

  modport slave (
    input  flush, start, stall,
    output en, ctrl_vars, busy, done
  );
endinterface

// File: rtl/stencil_op_affine_ctrl.sv
// Affine iteration-domain controller: walks a 3-deep loop nest at a fixed II and drives
// one stencil buffer port. Define AFFINE_CTRL_STALL_EN to honour the stall input.
module stencil_op_affine_ctrl #(
  parameter int unsigned EXTENT_0    = 1,
  parameter int unsigned EXTENT_1    = 128,
  parameter int unsigned EXTENT_2    = 128,
  parameter int unsigned II          = 1,
  parameter int unsigned START_DELAY = 0
) (
  input logic                     clk,
  input logic                     rst,
  stencil_op_affine_ctrl_if.slave bus
);

  localparam logic [15:0] Last0      = 16'(EXTENT_0 - 1);
  localparam logic [15:0] Last1      = 16'(EXTENT_1 - 1);
  localparam logic [15:0] Last2      = 16'(EXTENT_2 - 1);
  localparam logic [7:0]  IiReload   = 8'(II - 1);
  localparam int unsigned DelayLoadI = (START_DELAY == 0) ? 0 : START_DELAY - 1;
  localparam logic [15:0] DelayLoad  = 16'(DelayLoadI);

  typedef enum logic [1:0] {StIdle, StDelay, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      delay_q, delay_d;
  logic [7:0]       ii_q, ii_d;
  logic [2:0][15:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0][15:0] vars_q, vars_d;

  logic stall_eff;
  logic accept;
  logic issue;
  logic last_iter;

`ifdef AFFINE_CTRL_STALL_EN
  assign stall_eff = bus.stall;
`else
  // Static schedule: the port exists for a uniform interface but has no effect.
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign stall_eff    = 1'b0;
`endif

  // A start seen while the done pulse is visible belongs to the finished run.
  assign accept    = (state_q == StIdle) && bus.start && !done_q;
  assign issue     = (state_q == StRun) && !stall_eff && (ii_q == 8'd0);
  assign last_iter = (cnt_q[0] == Last0) && (cnt_q[1] == Last1) && (cnt_q[2] == Last2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      delay_q <= '0;
      ii_q    <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vars_q  <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      ii_q    <= ii_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vars_q  <= vars_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (START_DELAY == 0) ? StRun : StDelay;
      StDelay: if (!stall_eff && delay_q == 16'd0) state_d = StRun;
      StRun:   if (issue && last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  // Delay, II and loop counters; inner index fastest, all wrap to zero after the last one.
  always_comb begin
    delay_d = delay_q;
    ii_d    = ii_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      delay_d = '0;
      ii_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            delay_d = DelayLoad;
            ii_d    = '0;
            cnt_d   = '0;
          end
        end
        StDelay: begin
          if (!stall_eff && delay_q != 16'd0) delay_d = delay_q - 16'd1;
        end
        StRun: begin
          if (!stall_eff) begin
            if (ii_q != 8'd0) begin
              ii_d = ii_q - 8'd1;
            end else begin
              ii_d = IiReload;
              if (cnt_q[2] == Last2) begin
                cnt_d[2] = '0;
                if (cnt_q[1] == Last1) begin
                  cnt_d[1] = '0;
                  cnt_d[0] = (cnt_q[0] == Last0) ? 16'd0 : cnt_q[0] + 16'd1;
                end else begin
                  cnt_d[1] = cnt_q[1] + 16'd1;
                end
              end else begin
                cnt_d[2] = cnt_q[2] + 16'd1;
              end
            end
          end
        end
        StDone: begin
          cnt_d = '0;
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  // Registered outputs; ctrl_vars only move on an access.
  always_comb begin
    en_d   = issue;
    busy_d = (state_q == StDelay) || (state_q == StRun);
    done_d = (state_q == StDone);
    vars_d = issue ? cnt_q : vars_q;
    if (bus.flush) begin
      en_d   = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      vars_d = '0;
    end
  end

  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ctrl_vars = vars_q;

endmodule
